y_seq_detector: RTL and testbench
=================================

Name: y_seq_detector

Overview:
- Downstream consumer of the structural_model output `y`.
- Samples `y` as a serial bit stream, qualified by a valid strobe, and detects a parameterised bit pattern, with overlapping matches allowed.
- Produces a registered one-cycle match pulse, a saturating match counter and a sticky saturation flag.
- Used by the lab bench and by a downstream LED/display stage to count pattern occurrences.

Parameters:
- PAT_LEN, 4, pattern length in bits (2..16).
- PATTERN, 4'b1011, target pattern. MSB is the oldest bit received; LSB is the newest.
- COUNT_W, 8, match counter width.

Ports:
- clk, input, 1, single system clock; all state updates on rising edge.
- reset, input, 1, synchronous active-high reset.
- bit_in, input, 1, serial data bit (driven by structural_model `y`).
- bit_valid, input, 1, bit_in is sampled only when 1.
- clear, input, 1, synchronous soft clear of history, counter and flags.
- match, output, 1, one-cycle pulse: pattern completed by the last accepted bit.
- match_count, output, COUNT_W, number of matches since reset/clear; saturates.
- count_sat, output, 1, sticky: match_count reached all-ones.
- primed, output, 1, at least PAT_LEN bits accepted since reset/clear.

Behaviour:
- Reset (reset=1 at a rising edge): history=0, fill=0, match=0, match_count=0, count_sat=0, primed=0. Reset has priority over clear and bit_valid.
- clear=1 (reset=0): same effect as reset, one cycle. A bit presented with bit_valid in the same cycle is discarded. Clear wins.
- Accept (bit_valid=1, reset=0, clear=0):
  - history <= {history[PAT_LEN-2:0], bit_in}.
  - fill increments, saturating at PAT_LEN.
  - primed = (fill == PAT_LEN), registered.
- Match condition: evaluated on the shifted value, i.e. new_history == PATTERN, and (fill+1 >= PAT_LEN) at acceptance.
  - match is registered: asserted the cycle after the rising edge that accepted the completing bit (latency 1 clock from the accepting edge), high for exactly one cycle.
- match is 0 in any cycle whose preceding edge did not accept a bit; bit_valid=0 holds history and fill.
- Overlap: history is never flushed on a match. For PATTERN=1011, the stream 1011011 yields 2 matches.
- Before primed: no match, even if the zero-padded history equals PATTERN (e.g. PATTERN=0011 after receiving 11 does not match).
- Counter:
  - match_count increments in the same cycle match is asserted.
  - At 2^COUNT_W-1 it holds; count_sat is set the cycle match_count becomes all-ones.
  - count_sat stays set until reset/clear.
- Control states (encoded via fill): FILLING (fill<PAT_LEN) -> PRIMED (fill==PAT_LEN) on the PAT_LEN-th accepted bit. PRIMED -> FILLING only on reset/clear.
- No combinational path from inputs to outputs; all outputs are registered.
- X on bit_in while bit_valid=0 must not propagate.

Decomposition:
- Package y_seq_pkg:
  - DEFAULT_PATTERN and DEFAULT_PAT_LEN constants.
  - fill_w(PAT_LEN) helper returning $clog2(PAT_LEN+1).
  - typedef for the fill state (FILLING/PRIMED enum, used for debug/assertions).
- Sub-module sat_counter (parameter W; ports clk, reset, clr, inc, count, sat) implements the saturating counter and sticky flag. It is instantiated once.
- Shift history, fill logic and compare stay in y_seq_detector.

Test Plan:
- Reset then idle: reset=1 for 1 edge, bit_valid=0 for 10 cycles -> match=0, match_count=0, count_sat=0, primed=0 throughout.
- Single match: feed 1,0,1,1 with bit_valid=1 each cycle -> primed=1 after the 4th bit; match=1 exactly one cycle after the 4th accepting edge; match_count=1.
- Overlap and gaps: feed 1,0,1,1,0,1,1 with bit_valid toggling 1/0 between bits -> history holds during gaps; match_count=2; match pulses only after the 4th and 7th accepted bits.
- Priming guard: PATTERN=4'b0011; after reset feed 1,1 -> no match. Then feed 0,0,1,1 -> match_count=1.
- Saturation: COUNT_W=2; feed 1011 then repeated 011 -> match_count steps 1,2,3 then holds at 3; count_sat=1 from the 3rd match and stays set.
- Clear collision: assert clear with bit_valid=1 and bit_in completing the pattern -> no match; match_count=0, primed=0 next cycle. Repeat with reset mid-stream -> same result.

Source files
------------

// File: rtl/y_seq_detector_pkg.sv
// Shared constants, helpers and types for the y-stream pattern detector.
package y_seq_pkg;

    localparam int             DEFAULT_PAT_LEN = 4;
    localparam logic [3:0]     DEFAULT_PATTERN = 4'b1011;
    localparam int             DEFAULT_COUNT_W = 8;

    // Width needed to hold a fill count from 0 up to and including pat_len.
    function automatic int fill_w(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

    // Coarse control state of the history buffer: still filling, or holding
    // a full window of PAT_LEN accepted bits.
    typedef enum logic {
        FILLING = 1'b0,
        PRIMED  = 1'b1
    } fill_state_t;

endpackage

// File: rtl/y_seq_detector_sat_counter.sv
// Saturating event counter with a sticky "reached all-ones" flag.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);

    localparam logic [W-1:0] COUNT_MAX = {W{1'b1}};

    logic [W-1:0] count_next;
    logic         sat_next;

    // Next count: clear wins, otherwise step unless already at the ceiling;
    // the flag latches the moment the count lands on all-ones.
    always_comb begin
        count_next = count;
        sat_next   = sat;
        if (clr) begin
            count_next = '0;
            sat_next   = 1'b0;
        end else begin
            if (inc && (count != COUNT_MAX)) begin
                count_next = count + 1'b1;
            end
            if (count_next == COUNT_MAX) begin
                sat_next = 1'b1;
            end
        end
    end

    // Count and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            sat   <= 1'b0;
        end else begin
            count <= count_next;
            sat   <= sat_next;
        end
    end

endmodule

// File: rtl/y_seq_detector.sv
// Serial pattern detector on the structural_model y stream: shifts in
// qualified bits, flags overlapping matches one cycle after the completing
// bit, and counts them with a saturating counter.
module y_seq_detector
    import y_seq_pkg::*;
#(
    parameter int                 PAT_LEN = DEFAULT_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int                 COUNT_W = DEFAULT_COUNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bit_in,
    input  logic               bit_valid,
    input  logic               clear,
    output logic               match,
    output logic [COUNT_W-1:0] match_count,
    output logic               count_sat,
    output logic               primed
);

    localparam int            FW       = fill_w(PAT_LEN);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] history;
    logic [PAT_LEN-1:0] history_next;
    logic [FW-1:0]      fill;
    logic [FW-1:0]      fill_next;
    fill_state_t        state;
    fill_state_t        state_next;
    logic               match_next;

    // Next history, fill level, control state and match decision. The
    // match is judged on the freshly shifted window and only once the
    // accepting bit brings the fill up to a full window, so zero padding
    // left over from reset can never fake a match. Nothing here looks at
    // bit_in unless bit_valid is set, which keeps an undriven y contained.
    always_comb begin
        history_next = history;
        fill_next    = fill;
        state_next   = state;
        match_next   = 1'b0;
        if (clear) begin
            history_next = '0;
            fill_next    = '0;
            state_next   = FILLING;
        end else if (bit_valid) begin
            history_next = {history[PAT_LEN-2:0], bit_in};
            if (fill != FILL_MAX) begin
                fill_next = fill + 1'b1;
            end
            if (fill_next == FILL_MAX) begin
                state_next = PRIMED;
            end
            match_next = (history_next == PATTERN) && (fill >= (FILL_MAX - 1'b1));
        end
    end

    // State registers; reset overrides everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            history <= '0;
            fill    <= '0;
            state   <= FILLING;
            match   <= 1'b0;
        end else begin
            history <= history_next;
            fill    <= fill_next;
            state   <= state_next;
            match   <= match_next;
        end
    end

    assign primed = (state == PRIMED);

    sat_counter #(
        .W(COUNT_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (match_next),
        .count (match_count),
        .sat   (count_sat)
    );

endmodule

// File: tb/tb_y_seq_detector.sv
// Bench for y_seq_detector: directed vector table, hand sequences for the
// priming guard and saturation, then randomized traffic against a model.
module tb_y_seq_detector;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;
    logic clear = 1'b0;

    logic       ma, sa, pa;
    logic [7:0] ca;
    logic       mb, sb, pb;
    logic [7:0] cb;
    logic       mc, sc, pc;
    logic [1:0] cc;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    // A: default pattern 1011, 8-bit count
    y_seq_detector dut_a (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
        .match(ma), .match_count(ca), .count_sat(sa), .primed(pa)
    );

    // B: pattern 0011 for the priming guard
    y_seq_detector #(.PAT_LEN(4), .PATTERN(4'b0011), .COUNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
        .match(mb), .match_count(cb), .count_sat(sb), .primed(pb)
    );

    // C: pattern 1011, 2-bit count for saturation
    y_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .COUNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
        .match(mc), .match_count(cc), .count_sat(sc), .primed(pc)
    );

    // Reference model: the list of bits accepted since the last reset/clear.
    bit         acc[$];
    logic [3:0] pat [3] = '{4'b1011, 4'b0011, 4'b1011};
    int         cmax[3] = '{255, 255, 3};
    int         cnt [3];
    logic       em  [3];
    logic       ep;
    logic       es  [3];

    function automatic bit tailMatches(input logic [3:0] p);
        for (int i = 0; i < 4; i++) begin
            if (acc[acc.size() - 1 - i] != p[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic modelStep(input logic r, input logic c, input logic v, input logic b);
        if (r || c) begin
            acc.delete();
            for (int k = 0; k < 3; k++) begin
                cnt[k] = 0;
                em[k]  = 1'b0;
            end
        end else if (v) begin
            acc.push_back(b);
            if (acc.size() > 32) void'(acc.pop_front());
            for (int k = 0; k < 3; k++) begin
                em[k] = (acc.size() >= 4) && tailMatches(pat[k]);
                if (em[k] && cnt[k] < cmax[k]) cnt[k] = cnt[k] + 1;
            end
        end else begin
            for (int k = 0; k < 3; k++) em[k] = 1'b0;
        end
        ep = (acc.size() >= 4);
        for (int k = 0; k < 3; k++) es[k] = (cnt[k] == cmax[k]);
    endtask

    task automatic applyStimulus(input logic r, input logic c, input logic v, input logic b);
        reset     = r;
        clear     = c;
        bit_valid = v;
        bit_in    = b;
        modelStep(r, c, v, b);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) passed = passed + 1;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic       rst, clr, vld, bin;
        logic       em;
        logic [7:0] ec;
        logic       ep, es;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic r, input logic c, input logic v, input logic b,
                          input logic m, input logic [7:0] n, input logic p, input logic s);
        vec_t t;
        t.rst = r; t.clr = c; t.vld = v; t.bin = b;
        t.em = m; t.ec = n; t.ep = p; t.es = s;
        vecs.push_back(t);
    endtask

    logic bseq [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic bm   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic bp   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int   bc   [6] = '{0, 0, 0, 0, 0, 1};

    logic cseq [13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic cm   [13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int   ccnt [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3};
    logic cs   [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        // rst clr vld bin | match count primed sat   (dut_a)
        addVec(1, 0, 0, 0,  0, 0, 0, 0);
        addVec(0, 0, 0, 1,  0, 0, 0, 0);
        addVec(0, 0, 0, 1,  0, 0, 0, 0);
        addVec(0, 0, 0, 0,  0, 0, 0, 0);
        addVec(0, 0, 1, 1,  0, 0, 0, 0);
        addVec(0, 0, 1, 0,  0, 0, 0, 0);
        addVec(0, 0, 1, 1,  0, 0, 0, 0);
        addVec(0, 0, 1, 1,  1, 1, 1, 0);
        addVec(0, 0, 0, 0,  0, 1, 1, 0);
        addVec(0, 1, 0, 0,  0, 0, 0, 0);
        addVec(0, 0, 1, 1,  0, 0, 0, 0);
        addVec(0, 0, 0, 1,  0, 0, 0, 0);
        addVec(0, 0, 1, 0,  0, 0, 0, 0);
        addVec(0, 0, 0, 1,  0, 0, 0, 0);
        addVec(0, 0, 1, 1,  0, 0, 0, 0);
        addVec(0, 0, 0, 0,  0, 0, 0, 0);
        addVec(0, 0, 1, 1,  1, 1, 1, 0);
        addVec(0, 0, 0, 1,  0, 1, 1, 0);
        addVec(0, 0, 1, 0,  0, 1, 1, 0);
        addVec(0, 0, 0, 0,  0, 1, 1, 0);
        addVec(0, 0, 1, 1,  0, 1, 1, 0);
        addVec(0, 0, 0, 1,  0, 1, 1, 0);
        addVec(0, 0, 1, 1,  1, 2, 1, 0);
        addVec(0, 0, 0, 0,  0, 2, 1, 0);
        addVec(0, 0, 1, 1,  0, 2, 1, 0);
        addVec(0, 0, 1, 0,  0, 2, 1, 0);
        addVec(0, 0, 1, 1,  0, 2, 1, 0);
        addVec(0, 1, 1, 1,  0, 0, 0, 0);
        addVec(0, 0, 0, 0,  0, 0, 0, 0);
        addVec(0, 0, 1, 1,  0, 0, 0, 0);
        addVec(0, 0, 1, 0,  0, 0, 0, 0);
        addVec(0, 0, 1, 1,  0, 0, 0, 0);
        addVec(0, 0, 1, 1,  1, 1, 1, 0);
        addVec(0, 0, 1, 1,  0, 1, 1, 0);
        addVec(0, 0, 1, 0,  0, 1, 1, 0);
        addVec(0, 0, 1, 1,  0, 1, 1, 0);
        addVec(1, 0, 1, 1,  0, 0, 0, 0);
        addVec(0, 0, 0, 0,  0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].clr, vecs[i].vld, vecs[i].bin);
            checkOutput($sformatf("vec%0d.match", i),  32'(ma), 32'(vecs[i].em));
            checkOutput($sformatf("vec%0d.count", i),  32'(ca), 32'(vecs[i].ec));
            checkOutput($sformatf("vec%0d.primed", i), 32'(pa), 32'(vecs[i].ep));
            checkOutput($sformatf("vec%0d.sat", i),    32'(sa), 32'(vecs[i].es));
        end

        // Priming guard on the 0011 detector
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 1, bseq[i]);
            checkOutput($sformatf("prime%0d.match", i),  32'(mb), 32'(bm[i]));
            checkOutput($sformatf("prime%0d.count", i),  32'(cb), 32'(bc[i]));
            checkOutput($sformatf("prime%0d.primed", i), 32'(pb), 32'(bp[i]));
        end

        // Saturation on the 2-bit counter
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(0, 0, 1, cseq[i]);
            checkOutput($sformatf("sat%0d.match", i), 32'(mc), 32'(cm[i]));
            checkOutput($sformatf("sat%0d.count", i), 32'(cc), 32'(ccnt[i]));
            checkOutput($sformatf("sat%0d.flag", i),  32'(sc), 32'(cs[i]));
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("sat_hold.count", 32'(cc), 32'd3);
        checkOutput("sat_hold.flag",  32'(sc), 32'd1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("sat_clear.count", 32'(cc), 32'd0);
        checkOutput("sat_clear.flag",  32'(sc), 32'd0);

        // Randomized traffic against the model, all three detectors
        applyStimulus(1, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            logic r, c, v, b;
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 99) < 70);
            b = 1'($urandom_range(0, 1));
            applyStimulus(r, c, v, b);
            checkOutput($sformatf("rnd%0d.a.match", n), 32'(ma), 32'(em[0]));
            checkOutput($sformatf("rnd%0d.a.count", n), 32'(ca), 32'(cnt[0]));
            checkOutput($sformatf("rnd%0d.a.primed", n), 32'(pa), 32'(ep));
            checkOutput($sformatf("rnd%0d.a.sat", n),   32'(sa), 32'(es[0]));
            checkOutput($sformatf("rnd%0d.b.match", n), 32'(mb), 32'(em[1]));
            checkOutput($sformatf("rnd%0d.b.count", n), 32'(cb), 32'(cnt[1]));
            checkOutput($sformatf("rnd%0d.b.primed", n), 32'(pb), 32'(ep));
            checkOutput($sformatf("rnd%0d.b.sat", n),   32'(sb), 32'(es[1]));
            checkOutput($sformatf("rnd%0d.c.match", n), 32'(mc), 32'(em[2]));
            checkOutput($sformatf("rnd%0d.c.count", n), 32'(cc), 32'(cnt[2]));
            checkOutput($sformatf("rnd%0d.c.primed", n), 32'(pc), 32'(ep));
            checkOutput($sformatf("rnd%0d.c.sat", n),   32'(sc), 32'(es[2]));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
